imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader with a combinational fetch port.
// Optional feature: define IMEM_LOAD_CHECKSUM_EN to enable the load_sum byte checksum.
module imem_loader #(
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_en,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    input  logic [ADDR_BITS-1:0] fetch_addr,
    output logic [31:0]          fetch_data,
    output logic                 load_busy,
    output logic                 load_done,
    output logic [ADDR_BITS:0]   word_count,
    output logic [7:0]           load_sum
);

    localparam int          DEPTH = 1 << ADDR_BITS;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [ADDR_BITS-1:0] waddr_q, waddr_d;
    logic [ADDR_BITS:0]   wcnt_q, wcnt_d;
    logic [23:0]          asm_q, asm_d;
    logic [31:0]          mem_q [DEPTH];
    logic [31:0]          mem_d [DEPTH];
    logic                 accept;
    logic                 load_start;

    // Next-state logic: byte assembly, word write-back and load sequencing.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        waddr_d    = waddr_q;
        wcnt_d     = wcnt_q;
        asm_d      = asm_q;
        mem_d      = mem_q;
        accept     = 1'b0;
        load_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (load_en) begin
                    load_start = 1'b1;
                    state_d    = S_LOAD;
                    idx_d      = '0;
                    waddr_d    = '0;
                    wcnt_d     = '0;
                end
            end
            S_LOAD: begin
                accept = byte_valid;
                if (accept) begin
                    if (idx_q == 2'd3) begin
                        mem_d[waddr_q] = {byte_data, asm_q};
                        waddr_d        = waddr_q + ADDR_BITS'(1);
                        wcnt_d         = wcnt_q + (ADDR_BITS + 1)'(1);
                        idx_d          = '0;
                        if (&waddr_q) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        // Shift in from the top so byte 0 ends up in [7:0].
                        asm_d = {byte_data, asm_q[23:8]};
                        idx_d = idx_q + 2'd1;
                    end
                end
                // Dropping load_en abandons any partially assembled word.
                if (!load_en) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            S_DONE: begin
                if (!load_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and memory registers; reset refills the memory with NOPs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            waddr_q <= '0;
            wcnt_q  <= '0;
            asm_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            waddr_q <= waddr_d;
            wcnt_q  <= wcnt_d;
            asm_q   <= asm_d;
            mem_q   <= mem_d;
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;

    // Running mod-256 sum of accepted bytes, cleared on load entry.
    always_comb begin
        sum_d = sum_q;
        if (load_start) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + byte_data;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign load_sum = sum_q;
`else
    assign load_sum = 8'h00;
`endif

    assign byte_ready = (state_q == S_LOAD);
    assign load_busy  = (state_q == S_LOAD);
    assign load_done  = (state_q == S_DONE);
    assign word_count = wcnt_q;
    assign fetch_data = (state_q == S_LOAD) ? NOP : mem_q[fetch_addr];

endmodule
